// File: rtl/kbd_scan_decoder_if.sv
// Byte input, event output and overflow-status bundle of the scan-code post-processor.
// The slave side is the decoder and the master side is the byte source plus the event consumer.
interface kbd_scan_decoder_if;
   logic [7:0] kbd_data_p;
   logic       kbd_data_a;
   logic [9:0] evt_data;
   logic       evt_valid;
   logic       evt_ready;
   logic       ovf;
   logic [7:0] drop_cnt;
   logic       clr_ovf;

   modport master (
      output kbd_data_p, kbd_data_a, evt_ready, clr_ovf,
      input  evt_data, evt_valid, ovf, drop_cnt
   );

   modport slave (
      input  kbd_data_p, kbd_data_a, evt_ready, clr_ovf,
      output evt_data, evt_valid, ovf, drop_cnt
   );
endinterface

// File: rtl/kbd_scan_decoder.sv
// PS/2 set-2 prefix decoder: it turns byte sequences into {brk,ext,code} events.
// The events are queued in a first-word-fall-through FIFO that counts lost events.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for the first byte of a sequence
// ST_EXT     | E0 seen, waiting for an extended make code
// ST_BRK     | F0 seen, waiting for a break code
// ST_EXT_BRK | E0 F0 seen, waiting for an extended break code
// ST_PAUSE   | E1 seen, skipping the rest of the pause sequence
module kbd_scan_decoder #(
   parameter bit PASS_BREAK   = 1'b0,
   parameter bit SUPPRESS_REP = 1'b1,
   parameter int DEPTH        = 4,
   parameter int AW           = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   kbd_scan_decoder_if.slave   kbd
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_EXT     = 3'd1,
      ST_BRK     = 3'd2,
      ST_EXT_BRK = 3'd3,
      ST_PAUSE   = 3'd4
   } state_t;

   state_t     state, state_nxt;
   logic [2:0] skip_cnt, skip_cnt_nxt;
   logic       evt_form, evt_brk, evt_ext, evt_pause;
   logic [7:0] evt_code;

   logic [8:0] held_key;
   logic       held_vld;
   logic       held_hit;
   logic       push;

   logic [9:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          empty, full, pop, wr_en, lost;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         skip_cnt <= 3'd0;
      end else begin
         state    <= state_nxt;
         skip_cnt <= skip_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      skip_cnt_nxt = skip_cnt;
      evt_form     = 1'b0;
      evt_brk      = 1'b0;
      evt_ext      = 1'b0;
      evt_pause    = 1'b0;
      evt_code     = kbd.kbd_data_p;
      if (kbd.kbd_data_a) begin
         case (state)
            ST_IDLE: begin
               case (kbd.kbd_data_p)
                  8'hE0: state_nxt = ST_EXT;
                  8'hF0: state_nxt = ST_BRK;
                  8'hE1: begin
                     state_nxt    = ST_PAUSE;
                     skip_cnt_nxt = 3'd7;
                  end
                  // BAT, ACK, resend, echo and error bytes are not key events
                  8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: state_nxt = ST_IDLE;
                  default: evt_form = 1'b1;
               endcase
            end
            ST_EXT: begin
               if (kbd.kbd_data_p == 8'hF0) begin
                  state_nxt = ST_EXT_BRK;
               end else if (kbd.kbd_data_p != 8'hE0 && kbd.kbd_data_p != 8'hE1) begin
                  evt_form  = 1'b1;
                  evt_ext   = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
            ST_BRK: begin
               if (kbd.kbd_data_p != 8'hF0 && kbd.kbd_data_p != 8'hE0) begin
                  evt_form  = 1'b1;
                  evt_brk   = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
            ST_EXT_BRK: begin
               if (kbd.kbd_data_p != 8'hF0 && kbd.kbd_data_p != 8'hE0) begin
                  evt_form  = 1'b1;
                  evt_brk   = 1'b1;
                  evt_ext   = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
            ST_PAUSE: begin
               skip_cnt_nxt = skip_cnt - 3'd1;
               if (skip_cnt == 3'd1) begin
                  evt_form  = 1'b1;
                  evt_ext   = 1'b1;
                  evt_pause = 1'b1;
                  evt_code  = 8'hE1;
                  state_nxt = ST_IDLE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign held_hit = held_vld && (held_key == {evt_ext, evt_code});

   always_comb begin
      push = 1'b0;
      if (evt_form) begin
         if (evt_pause)    push = 1'b1;
         else if (evt_brk) push = PASS_BREAK;
         else              push = !(SUPPRESS_REP && held_hit);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_key <= 9'd0;
         held_vld <= 1'b0;
      end else if (evt_form && !evt_pause) begin
         if (!evt_brk) begin
            if (!(SUPPRESS_REP && held_hit)) begin
               held_key <= {evt_ext, evt_code};
               held_vld <= 1'b1;
            end
         end else if (held_hit) begin
            held_vld <= 1'b0;
         end
      end
   end

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign pop   = !empty && kbd.evt_ready;
   // A pop frees the slot in the same cycle, so a full FIFO still takes the push
   assign wr_en = push && (!full || pop);
   assign lost  = push && full && !pop;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= {evt_brk, evt_ext, evt_code};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kbd.ovf      <= 1'b0;
         kbd.drop_cnt <= 8'd0;
      end else begin
         if (lost)             kbd.ovf <= 1'b1;
         else if (kbd.clr_ovf) kbd.ovf <= 1'b0;
         if (kbd.clr_ovf)                    kbd.drop_cnt <= lost ? 8'd1 : 8'd0;
         else if (lost && kbd.drop_cnt != 8'hFF) kbd.drop_cnt <= kbd.drop_cnt + 8'd1;
      end
   end

   assign kbd.evt_valid = !empty;
   assign kbd.evt_data  = empty ? 10'd0 : mem[rd_ptr];

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Directed bench for kbd_scan_decoder. A PASS_BREAK=1 instance is checked in detail.
// A PASS_BREAK=0 instance is fed the same bytes and its popped events are collected.
module tb_kbd_scan_decoder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [9:0] q2 [$];

   always #5 clk = ~clk;

   kbd_scan_decoder_if kif ();
   kbd_scan_decoder_if kif2 ();

   kbd_scan_decoder #(.PASS_BREAK(1'b1), .SUPPRESS_REP(1'b1), .DEPTH(4), .AW(2)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kbd   (kif)
   );

   kbd_scan_decoder #(.PASS_BREAK(1'b0), .SUPPRESS_REP(1'b1), .DEPTH(4), .AW(2)) u_dut_nobrk (
      .clk   (clk),
      .rst_n (rst_n),
      .kbd   (kif2)
   );

   always @(posedge clk) begin
      if (kif2.evt_valid && kif2.evt_ready) q2.push_back(kif2.evt_data);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      kif.kbd_data_p  = b;
      kif.kbd_data_a  = 1'b1;
      kif2.kbd_data_p = b;
      kif2.kbd_data_a = 1'b1;
      @(negedge clk);
      kif.kbd_data_a  = 1'b0;
      kif2.kbd_data_a = 1'b0;
   endtask

   task automatic pop_expect(input string tag, input logic [9:0] exp);
      chk({tag, "_valid"}, kif.evt_valid, 1'b1);
      chk({tag, "_data"}, kif.evt_data, exp);
      kif.evt_ready = 1'b1;
      @(negedge clk);
      kif.evt_ready = 1'b0;
   endtask

   initial begin
      kif.kbd_data_p  = 8'h00;
      kif.kbd_data_a  = 1'b0;
      kif.evt_ready   = 1'b0;
      kif.clr_ovf     = 1'b0;
      kif2.kbd_data_p = 8'h00;
      kif2.kbd_data_a = 1'b0;
      kif2.evt_ready  = 1'b1;
      kif2.clr_ovf    = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_valid", kif.evt_valid, 1'b0);
      chk("rst_data", kif.evt_data, 10'h000);
      chk("rst_ovf", kif.ovf, 1'b0);
      chk("rst_drop", kif.drop_cnt, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      // make then break with latency checks
      send_byte(8'h1C);
      pop_expect("t1_make", 10'h01C);
      chk("t1_empty", kif.evt_valid, 1'b0);
      send_byte(8'hF0);
      chk("t1_prefix_noevt", kif.evt_valid, 1'b0);
      send_byte(8'h1C);
      pop_expect("t1_break", 10'h21C);

      // extended make and extended break
      send_byte(8'hE0);
      send_byte(8'h75);
      pop_expect("t2_extmake", 10'h175);
      send_byte(8'hE0);
      send_byte(8'hF0);
      chk("t2_prefix_noevt", kif.evt_valid, 1'b0);
      send_byte(8'h75);
      pop_expect("t2_extbreak", 10'h375);

      // typematic repeat suppression
      send_byte(8'h1C);
      send_byte(8'h1C);
      send_byte(8'h1C);
      send_byte(8'hF0);
      send_byte(8'h1C);
      send_byte(8'h1C);
      pop_expect("t3_ev0", 10'h01C);
      pop_expect("t3_ev1", 10'h21C);
      pop_expect("t3_ev2", 10'h01C);
      chk("t3_empty", kif.evt_valid, 1'b0);

      chk("nobrk_count", q2.size(), 4);
      chk("nobrk_ev0", q2[0], 10'h01C);
      chk("nobrk_ev1", q2[1], 10'h175);
      chk("nobrk_ev2", q2[2], 10'h01C);
      chk("nobrk_ev3", q2[3], 10'h01C);

      // pause sequence
      send_byte(8'hE1);
      send_byte(8'h14);
      send_byte(8'h77);
      send_byte(8'hE1);
      send_byte(8'hF0);
      send_byte(8'h14);
      send_byte(8'hF0);
      chk("t4_midpause", kif.evt_valid, 1'b0);
      send_byte(8'h77);
      pop_expect("t4_pause", 10'h1E1);
      chk("t4_single", kif.evt_valid, 1'b0);
      send_byte(8'hAA);
      chk("t4_bat_drop", kif.evt_valid, 1'b0);
      send_byte(8'h15);
      pop_expect("t4_idle_make", 10'h015);

      // overflow accounting with the consumer stalled
      send_byte(8'h21);
      send_byte(8'h22);
      send_byte(8'h23);
      send_byte(8'h24);
      chk("t5_full_noovf", kif.ovf, 1'b0);
      send_byte(8'h26);
      send_byte(8'h2A);
      chk("t5_ovf", kif.ovf, 1'b1);
      chk("t5_drop", kif.drop_cnt, 8'd2);
      @(negedge clk);
      kif.kbd_data_p  = 8'h2B;
      kif.kbd_data_a  = 1'b1;
      kif2.kbd_data_p = 8'h2B;
      kif2.kbd_data_a = 1'b1;
      kif.clr_ovf     = 1'b1;
      @(negedge clk);
      kif.kbd_data_a  = 1'b0;
      kif2.kbd_data_a = 1'b0;
      kif.clr_ovf     = 1'b0;
      chk("t5_clrloss_ovf", kif.ovf, 1'b1);
      chk("t5_clrloss_drop", kif.drop_cnt, 8'd1);
      kif.clr_ovf = 1'b1;
      @(negedge clk);
      kif.clr_ovf = 1'b0;
      chk("t5_clr_ovf", kif.ovf, 1'b0);
      chk("t5_clr_drop", kif.drop_cnt, 8'd0);
      pop_expect("t5_ev0", 10'h021);
      pop_expect("t5_ev1", 10'h022);
      pop_expect("t5_ev2", 10'h023);
      pop_expect("t5_ev3", 10'h024);
      chk("t5_empty", kif.evt_valid, 1'b0);

      // push and pop together while full
      send_byte(8'h31);
      send_byte(8'h32);
      send_byte(8'h33);
      send_byte(8'h34);
      @(negedge clk);
      kif.kbd_data_p  = 8'h35;
      kif.kbd_data_a  = 1'b1;
      kif2.kbd_data_p = 8'h35;
      kif2.kbd_data_a = 1'b1;
      kif.evt_ready   = 1'b1;
      @(negedge clk);
      kif.kbd_data_a  = 1'b0;
      kif2.kbd_data_a = 1'b0;
      kif.evt_ready   = 1'b0;
      chk("t5b_noovf", kif.ovf, 1'b0);
      pop_expect("t5b_ev0", 10'h032);
      pop_expect("t5b_ev1", 10'h033);
      pop_expect("t5b_ev2", 10'h034);
      pop_expect("t5b_ev3", 10'h035);
      chk("t5b_empty", kif.evt_valid, 1'b0);

      // asynchronous reset mid-sequence
      send_byte(8'h41);
      send_byte(8'h42);
      send_byte(8'hE0);
      chk("t6_pre_valid", kif.evt_valid, 1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", kif.evt_valid, 1'b0);
      chk("t6_rst_data", kif.evt_data, 10'h000);
      @(negedge clk);
      rst_n = 1'b1;
      send_byte(8'h75);
      pop_expect("t6_after", 10'h075);
      chk("t6_empty", kif.evt_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
